// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Front-panel time-set controller. A write pulse in IDLE snapshots the live
// time into an edit buffer; value/select pulses then adjust one field
// (hour, minute or second) with wrap-around. A second write pulse issues a
// one-cycle load strobe so the clock core can take the edited time.
//
// Optional feature (macro TIME_SET_TIMEOUT_EN): an edit with no button
// activity for TIMEOUT_TICKS timebase ticks is abandoned without a load.
// With the macro undefined there is no counter and i_tick is unused.
//
// Ports
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_tick                          timebase enable pulse (timeout only)
//   i_wr_pulse                      enter edit / commit edit
//   i_val_inc_pulse/i_val_dec_pulse adjust the selected field by +-1
//   i_sel_inc_pulse/i_sel_dec_pulse select next/previous field
//   i_cur_hr/min/sec                live time, snapshotted on edit entry
//   o_edit_mode                     high in EDIT and COMMIT
//   o_sel                           0=hour, 1=minute, 2=second
//   o_set_hr/min/sec                edit buffer
//   o_load                          one-cycle commit strobe
// ---------------------------------------------------------------------------
module time_set_ctrl #(
  parameter int HR_MAX        = 23,
  parameter int MS_MAX        = 59,
  parameter int TIMEOUT_TICKS = 10000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_wr_pulse,
  input  logic       i_val_inc_pulse,
  input  logic       i_val_dec_pulse,
  input  logic       i_sel_inc_pulse,
  input  logic       i_sel_dec_pulse,
  input  logic [4:0] i_cur_hr,
  input  logic [5:0] i_cur_min,
  input  logic [5:0] i_cur_sec,
  output logic       o_edit_mode,
  output logic [1:0] o_sel,
  output logic [4:0] o_set_hr,
  output logic [5:0] o_set_min,
  output logic [5:0] o_set_sec,
  output logic       o_load
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [4:0] HR_MAX_V = 5'(HR_MAX);
  localparam logic [5:0] MS_MAX_V = 6'(MS_MAX);

  logic [1:0] state;

  // An inc/dec pair only acts when exactly one of its two pulses is present;
  // both together cancel.
  logic sel_step, val_step, any_pulse, timeout_hit;
  logic [1:0] sel_next;

  assign sel_step  = i_sel_inc_pulse ^ i_sel_dec_pulse;
  assign val_step  = i_val_inc_pulse ^ i_val_dec_pulse;
  assign any_pulse = i_wr_pulse | i_val_inc_pulse | i_val_dec_pulse |
                     i_sel_inc_pulse | i_sel_dec_pulse;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_next = o_sel;
    if (i_sel_inc_pulse) sel_next = (o_sel >= 2'd2) ? 2'd0 : o_sel + 2'd1;
    else                 sel_next = (o_sel == 2'd0) ? 2'd2 : o_sel - 2'd1;
  end

  // Wrap-around +-1 over the range 0..max. Values above max (only possible
  // for a corrupted buffer) are pulled back into range.
  function automatic logic [5:0] step_val(input logic [5:0] v,
                                          input logic [5:0] max,
                                          input logic       up);
    if (up) return (v >= max) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0 || v > max) ? max : v - 6'd1;
  endfunction

`ifdef TIME_SET_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);

  logic [CNT_W-1:0] tick_cnt;

  // Counts idle ticks while editing; any button activity restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          tick_cnt <= '0;
    else if (state != ST_EDIT || any_pulse) tick_cnt <= '0;
    else if (i_tick)                       tick_cnt <= tick_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_EDIT) && i_tick && !any_pulse &&
                       (tick_cnt == CNT_W'(TIMEOUT_TICKS - 1));
`else
  logic unused_tick;
  assign unused_tick = i_tick;
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: all registers here are control/buffer flops, so each is cleared by
  // the asynchronous reset; there is no memory array to leave unreset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_edit_mode <= 1'b0;
      o_sel       <= 2'd0;
      o_set_hr    <= '0;
      o_set_min   <= '0;
      o_set_sec   <= '0;
      o_load      <= 1'b0;
    end else begin
      o_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_wr_pulse) begin
            state       <= ST_EDIT;
            o_edit_mode <= 1'b1;
            o_sel       <= 2'd0;
            o_set_hr    <= (i_cur_hr  > HR_MAX_V) ? 5'd0 : i_cur_hr;
            o_set_min   <= (i_cur_min > MS_MAX_V) ? 6'd0 : i_cur_min;
            o_set_sec   <= (i_cur_sec > MS_MAX_V) ? 6'd0 : i_cur_sec;
          end
        end
        ST_EDIT: begin
          if (i_wr_pulse) begin
            state  <= ST_COMMIT;
            o_load <= 1'b1;
          end else if (timeout_hit) begin
            state       <= ST_IDLE;
            o_edit_mode <= 1'b0;
          end else if (sel_step) begin
            o_sel <= sel_next;
          end else if (val_step) begin
            case (o_sel)
              2'd0:    o_set_hr  <= 5'(step_val({1'b0, o_set_hr}, {1'b0, HR_MAX_V},
                                                i_val_inc_pulse));
              2'd1:    o_set_min <= step_val(o_set_min, MS_MAX_V, i_val_inc_pulse);
              default: o_set_sec <= step_val(o_set_sec, MS_MAX_V, i_val_inc_pulse);
            endcase
          end
        end
        ST_COMMIT: begin
          state       <= ST_IDLE;
          o_edit_mode <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          o_edit_mode <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed bench for time_set_ctrl. Each step drives a set of pulses for one
// clock, pushes the expected outputs to a scoreboard queue, and pops/compares
// them one time unit after the rising edge. Build with +define+
// TIME_SET_TIMEOUT_EN to exercise the edit timeout (TIMEOUT_TICKS=4).
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;

`ifdef TIME_SET_TIMEOUT_EN
  localparam int TO_TICKS = 4;
`else
  localparam int TO_TICKS = 10000;
`endif

  typedef struct packed {
    logic       edit;
    logic [1:0] sel;
    logic [4:0] hr;
    logic [5:0] mn;
    logic [5:0] sc;
    logic       load;
  } obs_t;

  // pulse bit positions: {tick, sel_dec, sel_inc, val_dec, val_inc, wr}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] WR   = 6'b000001;
  localparam logic [5:0] VI   = 6'b000010;
  localparam logic [5:0] VD   = 6'b000100;
  localparam logic [5:0] SI   = 6'b001000;
  localparam logic [5:0] SD   = 6'b010000;
  localparam logic [5:0] TK   = 6'b100000;

  logic       clk, rst_n;
  logic       tick, wr, val_inc, val_dec, sel_inc, sel_dec;
  logic [4:0] cur_hr;
  logic [5:0] cur_min, cur_sec;
  logic       edit_mode, load;
  logic [1:0] sel;
  logic [4:0] set_hr;
  logic [5:0] set_min, set_sec;

  int   errors = 0;
  int   checks = 0;
  obs_t sb_q[$];
  string tag_q[$];

  time_set_ctrl #(.HR_MAX(23), .MS_MAX(59), .TIMEOUT_TICKS(TO_TICKS)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_tick          (tick),
    .i_wr_pulse      (wr),
    .i_val_inc_pulse (val_inc),
    .i_val_dec_pulse (val_dec),
    .i_sel_inc_pulse (sel_inc),
    .i_sel_dec_pulse (sel_dec),
    .i_cur_hr        (cur_hr),
    .i_cur_min       (cur_min),
    .i_cur_sec       (cur_sec),
    .o_edit_mode     (edit_mode),
    .o_sel           (sel),
    .o_set_hr        (set_hr),
    .o_set_min       (set_min),
    .o_set_sec       (set_sec),
    .o_load          (load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic e, input logic [1:0] s,
                              input int h, input int m, input int c,
                              input logic l);
    obs_t o;
    o.edit = e; o.sel = s; o.hr = 5'(h); o.mn = 6'(m); o.sc = 6'(c); o.load = l;
    return o;
  endfunction

  task automatic expect_out(input string tag, input obs_t exp);
    sb_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    obs_t  exp, act;
    string tag;
    exp = sb_q.pop_front();
    tag = tag_q.pop_front();
    act = {edit_mode, sel, set_hr, set_min, set_sec, load};
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got edit=%0b sel=%0d %0d:%0d:%0d load=%0b, exp edit=%0b sel=%0d %0d:%0d:%0d load=%0b",
             tag, act.edit, act.sel, act.hr, act.mn, act.sc, act.load,
             exp.edit, exp.sel, exp.hr, exp.mn, exp.sc, exp.load);
    end
  endtask

  // Called at posedge+1: drive pulses for one cycle, then compare.
  task automatic step(input string tag, input logic [5:0] p, input obs_t exp);
    {tick, sel_dec, sel_inc, val_dec, val_inc, wr} = p;
    expect_out(tag, exp);
    @(posedge clk);
    #1;
    {tick, sel_dec, sel_inc, val_dec, val_inc, wr} = NONE;
    check();
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hr = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {tick, sel_dec, sel_inc, val_dec, val_inc, wr} = NONE;
    set_cur(12, 34, 56);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_state", mk(0, 0, 0, 0, 0, 0));
    check();
    rst_n = 1'b1;

    // IDLE ignores value/select pulses; the first wr is honoured.
    step("idle_ignore", VI | SD, mk(0, 0, 0, 0, 0, 0));
    step("enter_edit", WR, mk(1, 0, 12, 34, 56, 0));
    step("hr_inc", VI, mk(1, 0, 13, 34, 56, 0));
    step("hr_dec", VD, mk(1, 0, 12, 34, 56, 0));
    step("sel_dec_wrap", SD, mk(1, 2, 12, 34, 56, 0));
    step("sec_inc", VI, mk(1, 2, 12, 34, 57, 0));
    step("sel_inc_wrap", SI, mk(1, 0, 12, 34, 57, 0));
    step("commit1", WR, mk(1, 0, 12, 34, 57, 1));
    // Pulses during COMMIT are ignored, including wr.
    step("commit_ignore", WR | VI | SI, mk(0, 0, 12, 34, 57, 0));
    step("idle_hold", NONE, mk(0, 0, 12, 34, 57, 0));

    // Wrap boundaries.
    set_cur(23, 59, 0);
    step("enter_edit2", WR, mk(1, 0, 23, 59, 0, 0));
    step("hr_wrap_up", VI, mk(1, 0, 0, 59, 0, 0));
    step("hr_wrap_dn", VD, mk(1, 0, 23, 59, 0, 0));
    step("hr_wrap_up2", VI, mk(1, 0, 0, 59, 0, 0));
    step("sel_min", SI, mk(1, 1, 0, 59, 0, 0));
    step("min_wrap_up", VI, mk(1, 1, 0, 0, 0, 0));
    step("sel_sec", SI, mk(1, 2, 0, 0, 0, 0));
    step("sec_wrap_dn", VD, mk(1, 2, 0, 0, 59, 0));
    step("sec_wrap_up", VI, mk(1, 2, 0, 0, 0, 0));
    step("sel_wrap_up", SI, mk(1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 7; i++) step("hr_walk", VI, mk(1, 0, i, 0, 0, 0));
    step("sel_min2", SI, mk(1, 1, 7, 0, 0, 0));
    for (int i = 1; i <= 5; i++) step("min_walk", VI, mk(1, 1, 7, i, 0, 0));

    // wr beats sel and val in the same cycle.
    step("commit_prio", WR | SI | VI, mk(1, 1, 7, 5, 0, 1));
    step("commit_done", NONE, mk(0, 1, 7, 5, 0, 0));
    step("commit_hold", NONE, mk(0, 1, 7, 5, 0, 0));

    // Opposing pulses cancel.
    set_cur(5, 10, 20);
    step("enter_edit3", WR, mk(1, 0, 5, 10, 20, 0));
    step("val_cancel", VI | VD, mk(1, 0, 5, 10, 20, 0));
    step("sel_cancel", SI | SD, mk(1, 0, 5, 10, 20, 0));
    step("sel_over_val", SI | VI, mk(1, 1, 5, 10, 20, 0));
    step("commit3", WR, mk(1, 1, 5, 10, 20, 1));
    step("idle3", NONE, mk(0, 1, 5, 10, 20, 0));

    // Out-of-range snapshot is clamped on entry.
    set_cur(30, 60, 63);
    step("clamp_entry", WR, mk(1, 0, 0, 0, 0, 0));
    step("clamp_commit", WR, mk(1, 0, 0, 0, 0, 1));

    // Reset in COMMIT: load drops immediately, outputs cleared.
    rst_n = 1'b0;
    #1;
    expect_out("rst_in_commit", mk(0, 0, 0, 0, 0, 0));
    check();
    @(posedge clk);
    #1;
    expect_out("rst_held", mk(0, 0, 0, 0, 0, 0));
    check();
    rst_n = 1'b1;
    set_cur(8, 9, 10);
    step("wr_after_rst", WR, mk(1, 0, 8, 9, 10, 0));
    step("hr_inc4", VI, mk(1, 0, 9, 9, 10, 0));

    // Reset mid-EDIT abandons the edit with no load.
    rst_n = 1'b0;
    #1;
    expect_out("rst_in_edit", mk(0, 0, 0, 0, 0, 0));
    check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("idle_after_rst", NONE, mk(0, 0, 0, 0, 0, 0));

    // Timeout behaviour.
    set_cur(1, 2, 3);
    step("enter_edit5", WR, mk(1, 0, 1, 2, 3, 0));
`ifdef TIME_SET_TIMEOUT_EN
    for (int i = 0; i < 3; i++) step("to_tick_a", TK, mk(1, 0, 1, 2, 3, 0));
    step("to_clear", VI, mk(1, 0, 2, 2, 3, 0));
    for (int i = 0; i < 3; i++) step("to_tick_b", TK, mk(1, 0, 2, 2, 3, 0));
    step("to_expire", TK, mk(0, 0, 2, 2, 3, 0));
    step("to_idle", TK, mk(0, 0, 2, 2, 3, 0));
`else
    for (int i = 0; i < 100; i++) step("no_timeout", TK, mk(1, 0, 1, 2, 3, 0));
    step("commit5", WR, mk(1, 0, 1, 2, 3, 1));
    step("idle5", NONE, mk(0, 0, 1, 2, 3, 0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
